// File: rtl/change_dispenser_if.sv
// Coin request channel between the change dispenser and the coin ejector.
//   coin_valid : dispenser has a coin request pending on coin
//   coin       : one-hot coin code (100 = quarter, 010 = dime, 001 = nickel)
//   coin_ready : ejector accepts the pending coin this cycle
interface change_dispenser_if;
    logic       coin_valid;
    logic [2:0] coin;
    logic       coin_ready;

    // Dispenser side drives the request, ejector side answers with ready.
    modport master (output coin_valid, output coin, input coin_ready);
    modport slave  (input coin_valid, input coin, output coin_ready);
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: captures the leftover balance when the vending FSM raises
// change and pays it out greedily (largest coin first), one coin per accepted
// valid/ready transfer on the coin channel.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   change       : vending FSM change flag, a rising edge starts a payout
//   balance      : amount in cents, sampled on the start edge
//   coin_bus     : coin request channel (coin_valid, coin, coin_ready)
//   busy         : payout in progress (ISSUE and DONE)
//   done         : one-cycle pulse when a payout completes
//   error        : one-cycle pulse when balance is not a multiple of N_VAL
//   coins_paid   : coins issued in the current or last payout, saturating
module change_dispenser #(
    parameter int unsigned Q_VAL = 25,
    parameter int unsigned D_VAL = 10,
    parameter int unsigned N_VAL = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       change,
    input  logic [7:0]                 balance,
    change_dispenser_if.master         coin_bus,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [7:0]                 coins_paid
);

    localparam int unsigned W = 8;

    localparam logic [W-1:0] Q_AMT = W'(Q_VAL);
    localparam logic [W-1:0] D_AMT = W'(D_VAL);
    localparam logic [W-1:0] N_AMT = W'(N_VAL);

    localparam logic [2:0] COIN_Q    = 3'b100;
    localparam logic [2:0] COIN_D    = 3'b010;
    localparam logic [2:0] COIN_N    = 3'b001;
    localparam logic [2:0] COIN_NONE = 3'b000;

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_t;

    // Largest coin not exceeding x; nickel is the floor since x is a multiple of N.
    function automatic logic [2:0] greedy(input logic [W-1:0] x);
        if (x >= Q_AMT) begin
            return COIN_Q;
        end else if (x >= D_AMT) begin
            return COIN_D;
        end else begin
            return COIN_N;
        end
    endfunction

    // Cent value of a one-hot coin code.
    function automatic logic [W-1:0] coin_value(input logic [2:0] c);
        case (c)
            COIN_Q:  return Q_AMT;
            COIN_D:  return D_AMT;
            COIN_N:  return N_AMT;
            default: return '0;
        endcase
    endfunction

    state_t       state_q, state_d;
    logic [W-1:0] remaining_q, remaining_d;
    logic         change_q;
    logic [2:0]   coin_q, coin_d;
    logic         coin_valid_q, coin_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         error_q, error_d;
    logic [W-1:0] coins_paid_q, coins_paid_d;

    logic         start;
    logic         transfer;
    logic [W-1:0] rem_after;

    // State and all output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            change_q     <= 1'b0;
            coin_q       <= COIN_NONE;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            coins_paid_q <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            change_q     <= change;
            coin_q       <= coin_d;
            coin_valid_q <= coin_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            coins_paid_q <= coins_paid_d;
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        coin_d       = coin_q;
        coins_paid_d = coins_paid_q;
        coin_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;

        start     = change & ~change_q;
        transfer  = coin_valid_q & coin_bus.coin_ready;
        rem_after = remaining_q - coin_value(coin_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    coins_paid_d = '0;
                    if ((balance % N_AMT) != '0) begin
                        state_d = ERR;
                    end else if (balance == '0) begin
                        state_d = DONE;
                    end else begin
                        remaining_d = balance;
                        coin_d      = greedy(balance);
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (transfer) begin
                    remaining_d = rem_after;
                    if (coins_paid_q != CNT_MAX) begin
                        coins_paid_d = coins_paid_q + W'(1);
                    end
                    if (rem_after == '0) begin
                        state_d = DONE;
                    end else begin
                        coin_d = greedy(rem_after);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                coins_paid_d = '0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the next state so they line up with the state register.
        if (state_d != ISSUE) begin
            coin_d = COIN_NONE;
        end
        coin_valid_d = (state_d == ISSUE);
        busy_d       = (state_d == ISSUE) || (state_d == DONE);
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERR);
    end

    assign coin_bus.coin_valid = coin_valid_q;
    assign coin_bus.coin       = coin_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign error               = error_q;
    assign coins_paid          = coins_paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser. Inputs change on the falling edge and
// outputs are sampled there too, half a cycle away from the active edge.
// obs packs {coin_valid, coin[2:0], busy, done, error}.
module tb_change_dispenser;

    logic       clock;
    logic       reset;
    logic       change;
    logic [7:0] balance;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] coins_paid;

    int passed;
    int total;

    change_dispenser_if bus ();

    change_dispenser #(
        .Q_VAL(25),
        .D_VAL(10),
        .N_VAL(5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .change     (change),
        .balance    (balance),
        .coin_bus   (bus.master),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .coins_paid (coins_paid)
    );

    wire [6:0] obs = {bus.coin_valid, bus.coin, busy, done, error};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset;
        logic [6:0] e;
        reset          = 1'b1;
        change         = 1'b0;
        balance        = 8'd0;
        bus.coin_ready = 1'b0;
        #1;
        e = 7'b0_000_0_0_0;
        total++;
        if (obs !== e) $display("FAIL reset_outputs: got %b exp %b", obs, e);
        else passed++;
        total++;
        if (coins_paid !== 8'd0) $display("FAIL reset_coins_paid: got %0d exp 0", coins_paid);
        else passed++;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (obs !== e) $display("FAIL reset_release_idle: got %b exp %b", obs, e);
        else passed++;
    endtask

    // 35 cents, ready held high: Q then D on consecutive cycles, then done.
    task automatic test_back_to_back;
        logic [6:0] e;
        bus.coin_ready = 1'b1;
        balance        = 8'd35;
        change         = 1'b1;
        @(negedge clock);
        change = 1'b0;
        e = 7'b1_100_1_0_0;
        total++;
        if (obs !== e) $display("FAIL b35_first_q: got %b exp %b", obs, e);
        else passed++;
        @(negedge clock);
        e = 7'b1_010_1_0_0;
        total++;
        if (obs !== e) $display("FAIL b35_second_d: got %b exp %b", obs, e);
        else passed++;
        @(negedge clock);
        e = 7'b0_000_1_1_0;
        total++;
        if (obs !== e) $display("FAIL b35_done: got %b exp %b", obs, e);
        else passed++;
        total++;
        if (coins_paid !== 8'd2) $display("FAIL b35_coins_paid: got %0d exp 2", coins_paid);
        else passed++;
        @(negedge clock);
        e = 7'b0_000_0_0_0;
        total++;
        if (obs !== e) $display("FAIL b35_idle_after: got %b exp %b", obs, e);
        else passed++;
    endtask

    // 7 cents is malformed: error pulse, coins_paid cleared; then 20 cents pays D, D.
    task automatic test_error_then_20;
        logic [6:0] e;
        bus.coin_ready = 1'b1;
        balance        = 8'd7;
        change         = 1'b1;
        @(negedge clock);
        change = 1'b0;
        e = 7'b0_000_0_0_1;
        total++;
        if (obs !== e) $display("FAIL err7_pulse: got %b exp %b", obs, e);
        else passed++;
        total++;
        if (coins_paid !== 8'd0) $display("FAIL err7_coins_paid: got %0d exp 0", coins_paid);
        else passed++;
        @(negedge clock);
        e = 7'b0_000_0_0_0;
        total++;
        if (obs !== e) $display("FAIL err7_pulse_end: got %b exp %b", obs, e);
        else passed++;
        balance = 8'd20;
        change  = 1'b1;
        @(negedge clock);
        change = 1'b0;
        e = 7'b1_010_1_0_0;
        total++;
        if (obs !== e) $display("FAIL b20_first_d: got %b exp %b", obs, e);
        else passed++;
        @(negedge clock);
        total++;
        if (obs !== e) $display("FAIL b20_second_d: got %b exp %b", obs, e);
        else passed++;
        @(negedge clock);
        e = 7'b0_000_1_1_0;
        total++;
        if (obs !== e) $display("FAIL b20_done: got %b exp %b", obs, e);
        else passed++;
        total++;
        if (coins_paid !== 8'd2) $display("FAIL b20_coins_paid: got %0d exp 2", coins_paid);
        else passed++;
        @(negedge clock);
    endtask

    // 15 cents with the ejector stalled for 3 cycles: D held, then D, then N.
    task automatic test_backpressure;
        logic [6:0] e;
        bus.coin_ready = 1'b0;
        balance        = 8'd15;
        change         = 1'b1;
        @(negedge clock);
        change = 1'b0;
        e = 7'b1_010_1_0_0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs !== e) $display("FAIL b15_stall_hold[%0d]: got %b exp %b", i, obs, e);
            else passed++;
            if (i < 2) @(negedge clock);
        end
        bus.coin_ready = 1'b1;
        @(negedge clock);
        e = 7'b1_001_1_0_0;
        total++;
        if (obs !== e) $display("FAIL b15_then_n: got %b exp %b", obs, e);
        else passed++;
        total++;
        if (coins_paid !== 8'd1) $display("FAIL b15_mid_count: got %0d exp 1", coins_paid);
        else passed++;
        @(negedge clock);
        e = 7'b0_000_1_1_0;
        total++;
        if (obs !== e) $display("FAIL b15_done: got %b exp %b", obs, e);
        else passed++;
        total++;
        if (coins_paid !== 8'd2) $display("FAIL b15_coins_paid: got %0d exp 2", coins_paid);
        else passed++;
        @(negedge clock);
    endtask

    // Zero balance: no coin, done one cycle after the start edge, count cleared.
    task automatic test_zero;
        logic [6:0] e;
        bus.coin_ready = 1'b1;
        balance        = 8'd0;
        change         = 1'b1;
        @(negedge clock);
        change = 1'b0;
        e = 7'b0_000_1_1_0;
        total++;
        if (obs !== e) $display("FAIL zero_done: got %b exp %b", obs, e);
        else passed++;
        total++;
        if (coins_paid !== 8'd0) $display("FAIL zero_coins_paid: got %0d exp 0", coins_paid);
        else passed++;
        @(negedge clock);
        e = 7'b0_000_0_0_0;
        total++;
        if (obs !== e) $display("FAIL zero_idle_after: got %b exp %b", obs, e);
        else passed++;
    endtask

    // 30 cents with a second change rising edge during ISSUE: ignored, Q then N only.
    task automatic test_ignore_restart;
        logic [6:0] e;
        bus.coin_ready = 1'b0;
        balance        = 8'd30;
        change         = 1'b1;
        @(negedge clock);
        change = 1'b0;
        e = 7'b1_100_1_0_0;
        total++;
        if (obs !== e) $display("FAIL b30_first_q: got %b exp %b", obs, e);
        else passed++;
        @(negedge clock);
        change         = 1'b1;
        balance        = 8'd50;
        bus.coin_ready = 1'b1;
        @(negedge clock);
        change = 1'b0;
        e = 7'b1_001_1_0_0;
        total++;
        if (obs !== e) $display("FAIL b30_then_n: got %b exp %b", obs, e);
        else passed++;
        @(negedge clock);
        e = 7'b0_000_1_1_0;
        total++;
        if (obs !== e) $display("FAIL b30_done: got %b exp %b", obs, e);
        else passed++;
        total++;
        if (coins_paid !== 8'd2) $display("FAIL b30_coins_paid: got %0d exp 2", coins_paid);
        else passed++;
        e = 7'b0_000_0_0_0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if (obs !== e) $display("FAIL b30_no_queued_start[%0d]: got %b exp %b", i, obs, e);
            else passed++;
        end
    endtask

    // Reset while a coin is pending: outputs clear at once, no done, no resume.
    task automatic test_reset_mid_payout;
        logic [6:0] e;
        bus.coin_ready = 1'b0;
        balance        = 8'd35;
        change         = 1'b1;
        @(negedge clock);
        change = 1'b0;
        e = 7'b1_100_1_0_0;
        total++;
        if (obs !== e) $display("FAIL rst_pending_q: got %b exp %b", obs, e);
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        e = 7'b0_000_0_0_0;
        total++;
        if (obs !== e) $display("FAIL rst_async_clear: got %b exp %b", obs, e);
        else passed++;
        total++;
        if (coins_paid !== 8'd0) $display("FAIL rst_async_count: got %0d exp 0", coins_paid);
        else passed++;
        @(negedge clock);
        reset          = 1'b0;
        bus.coin_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            total++;
            if (obs !== e) $display("FAIL rst_no_resume[%0d]: got %b exp %b", i, obs, e);
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_back_to_back();
        test_error_then_20();
        test_backpressure();
        test_zero();
        test_ignore_restart();
        test_reset_mid_payout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
